// File: rtl/core_trap_pkg.sv
// ============================================================================
// Module      : core_trap_pkg
// Description : Shared constants and types for the CoreN M-mode trap block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ENTER = 1'b1
  } trap_state_e;

endpackage

`default_nettype wire

// File: rtl/core_trap_csr.sv
// ============================================================================
// Module      : core_trap_csr
// Description : mstatus/mtvec/mepc/mcause storage, read mux and trap/mret merge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_trap_csr
  import core_trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            csr_wen,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [3:0]      trap_cause,
  input  logic            mret_take,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic [XLEN-1:0] mtvec_val,
  output logic [XLEN-1:0] mepc_val
);

  localparam logic [XLEN-1:0] c_align_mask = ~(XLEN'(3));

  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] w_mstatus;

  // Trap/mret updates are placed after the CSR write so they win on any shared field.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtvec  <= '0;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      if (csr_wen) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= csr_wdata[MSTATUS_MIE];
            r_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MTVEC:  r_mtvec  <= csr_wdata & c_align_mask;
          CSR_MEPC:   r_mepc   <= csr_wdata & c_align_mask;
          CSR_MCAUSE: r_mcause <= csr_wdata;
          default: ;
        endcase
      end
      if (trap_take) begin
        r_mepc   <= trap_pc & c_align_mask;
        r_mcause <= {{(XLEN-4){1'b0}}, trap_cause};
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (mret_take) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    w_mstatus               = '0;
    w_mstatus[MSTATUS_MIE]  = r_mie;
    w_mstatus[MSTATUS_MPIE] = r_mpie;
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = w_mstatus;
      CSR_MTVEC:   csr_rdata = r_mtvec;
      CSR_MEPC:    csr_rdata = r_mepc;
      CSR_MCAUSE:  csr_rdata = r_mcause;
      default:     csr_hit   = 1'b0;
    endcase
  end

  assign mtvec_val = r_mtvec;
  assign mepc_val  = r_mepc;

endmodule

`default_nettype wire

// File: rtl/core_trap_ctrl.sv
// ============================================================================
// Module      : core_trap_ctrl
// Description : M-mode trap responder: event priority, entry FSM, redirect/stall.
//               Build option CORE_TRAP_EBREAK_HALT_EN turns ebreak into a sticky halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_trap_ctrl
  import core_trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            mret,
  input  logic [XLEN-1:0] pc,
  input  logic            csr_wen,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            halt
);

  trap_state_e     r_state;
  trap_state_e     w_state_nxt;
  logic            w_halted;
  logic            w_idle;
  logic            w_ebreak_trap;
  logic            w_trap_take;
  logic            w_mret_take;
  logic [3:0]      w_trap_cause;
  logic [XLEN-1:0] w_mtvec;
  logic [XLEN-1:0] w_mepc;

`ifdef CORE_TRAP_EBREAK_HALT_EN
  logic r_halt;
  logic w_halt_set;

  assign w_ebreak_trap = 1'b0;
  assign w_halted      = r_halt;
  assign w_halt_set    = w_idle && ebreak && !ecall;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      r_halt <= 1'b0;
    else if (w_halt_set)
      r_halt <= 1'b1;
  end

  assign halt = r_halt;
`else
  assign w_ebreak_trap = ebreak;
  assign w_halted      = 1'b0;
  assign halt          = 1'b0;
`endif

  // ebreak still outranks mret even when it halts instead of trapping.
  assign w_idle       = (r_state == IDLE) && !w_halted;
  assign w_trap_take  = w_idle && (ecall || w_ebreak_trap);
  assign w_mret_take  = w_idle && mret && !ecall && !ebreak;
  assign w_trap_cause = ecall ? CAUSE_ECALL_M : CAUSE_BREAKPOINT;

  core_trap_csr #(
    .XLEN (XLEN)
  ) u_csr (
    .clk        (clk),
    .rst_b      (rst_b),
    .csr_wen    (csr_wen),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .trap_take  (w_trap_take),
    .trap_pc    (pc),
    .trap_cause (w_trap_cause),
    .mret_take  (w_mret_take),
    .csr_rdata  (csr_rdata),
    .csr_hit    (csr_hit),
    .mtvec_val  (w_mtvec),
    .mepc_val   (w_mepc)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      IDLE: begin
        if (w_trap_take) begin
          w_state_nxt = ENTER;
          stall       = 1'b1;
        end else if (w_mret_take) begin
          redirect_valid = 1'b1;
          redirect_pc    = w_mepc;
        end
      end
      ENTER: begin
        w_state_nxt    = IDLE;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = w_mtvec;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_halted)
      stall = 1'b1;
  end

endmodule

`default_nettype wire
